// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// Serial-to-parallel UART receive stage. Frame: start(0), 8 data bits LSB
// first, even parity, stop(1). The asynchronous rx line is synchronised by two
// flops, each bit is sampled at mid-bit, and parity and stop are checked. The
// received byte is presented with a one-cycle valid strobe plus error flags.
// A status LED is lit for LED_HOLD clocks after each error-free frame.
//
// Optional feature macro: RX_MAJORITY_EN
//   defined   : every sample is the 2-of-3 majority of rx_s taken at sample
//               point -2, -1 and 0 clocks. This rejects one glitch clock.
//   undefined : a single rx_s sample is taken at the sample point.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   UART serial input, asynchronous to clk, idle high
//   data_out   out  [7:0] last received byte
//   rx_valid   out  one-cycle pulse; data_out, parity_err and frame_err updated
//   rx_busy    out  frame reception in progress
//   parity_err out  last frame failed the even-parity check
//   frame_err  out  last frame had stop bit = 0
//   led        out  high for LED_HOLD clocks after an error-free frame
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int LED_HOLD     = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       parity_err,
    output logic       frame_err,
    output logic       led
);

    localparam int          LED_W    = $clog2(LED_HOLD + 1);
    localparam logic [13:0] HALF_END = 14'(CLKS_PER_BIT / 2 - 1);
    localparam logic [13:0] BIT_END  = 14'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // High when the received parity bit does not make the total count of ones even.
    function automatic logic parity_bad(input logic [7:0] data, input logic par_bit);
        return par_bit ^ (^data);
    endfunction

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, rx_prev_q;
    logic              rx_s;
    logic              samp_s;
    logic [13:0]       clk_count_q, clk_count_d;
    logic [2:0]        bit_index_q, bit_index_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_bad_q, par_bad_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic [LED_W-1:0]  led_cnt_q, led_cnt_d;
    logic              led_q, led_d;

    assign rx_s = sync2_q;

`ifdef RX_MAJORITY_EN
    logic rx_prev2_q;

    // Second history flop so the vote can see rx_s two clocks back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev2_q <= 1'b1;
        end else begin
            rx_prev2_q <= rx_prev_q;
        end
    end

    assign samp_s = maj3(rx_prev2_q, rx_prev_q, rx_s);
`else
    assign samp_s = rx_s;
`endif

    // Two-flop synchroniser plus one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clk_count_q <= 14'd0;
            bit_index_q <= 3'd0;
            shift_q     <= 8'd0;
            par_bad_q   <= 1'b0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            led_cnt_q   <= '0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            par_bad_q   <= par_bad_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            led_cnt_q   <= led_cnt_d;
            led_q       <= led_d;
        end
    end

    // Next-state and datapath logic for the receive FSM and LED timer.
    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        par_bad_d   = par_bad_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;

        if (led_cnt_q != '0) begin
            led_cnt_d = led_cnt_q - LED_W'(1);
        end else begin
            led_cnt_d = led_cnt_q;
        end

        case (state_q)
            IDLE: begin
                // Only a true falling edge starts a frame; a line stuck low does not.
                if (rx_prev_q && !rx_s) begin
                    clk_count_d = 14'd0;
                    busy_d      = 1'b1;
                    state_d     = START;
                end else begin
                    state_d     = IDLE;
                end
            end
            START: begin
                if (clk_count_q == HALF_END) begin
                    if (!samp_s) begin
                        clk_count_d = 14'd0;
                        bit_index_d = 3'd0;
                        state_d     = DATA;
                    end else begin
                        // Start bit not low at mid-bit: treat as a glitch.
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    clk_count_d = clk_count_q + 14'd1;
                end
            end
            DATA: begin
                if (clk_count_q == BIT_END) begin
                    clk_count_d          = 14'd0;
                    shift_d[bit_index_q] = samp_s;
                    if (bit_index_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end else begin
                    clk_count_d = clk_count_q + 14'd1;
                end
            end
            PARITY: begin
                if (clk_count_q == BIT_END) begin
                    clk_count_d = 14'd0;
                    par_bad_d   = parity_bad(shift_q, samp_s);
                    state_d     = STOP;
                end else begin
                    clk_count_d = clk_count_q + 14'd1;
                end
            end
            STOP: begin
                // Finishing mid-stop-bit leaves time to catch a back-to-back start edge.
                if (clk_count_q == BIT_END) begin
                    clk_count_d = 14'd0;
                    data_d      = shift_q;
                    perr_d      = par_bad_q;
                    ferr_d      = ~samp_s;
                    valid_d     = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                    if (!par_bad_q && samp_s) begin
                        led_cnt_d = LED_W'(LED_HOLD);
                    end else begin
                        led_cnt_d = led_cnt_d;
                    end
                end else begin
                    clk_count_d = clk_count_q + 14'd1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        led_d = (led_cnt_d != '0);
    end

    assign data_out   = data_q;
    assign rx_valid   = valid_q;
    assign rx_busy    = busy_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign led        = led_q;

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    localparam int CPB      = 16;
    localparam int LED_HOLD = 100;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_busy;
    logic       parity_err;
    logic       frame_err;
    logic       led;

    uart_receiver #(
        .CLKS_PER_BIT(CPB),
        .LED_HOLD    (LED_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         lat;
    } rec_t;

    typedef struct {
        logic [7:0] din;
        logic       par;
        logic       stop;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_led;
    } vec_t;

    rec_t q[$];
    int   cyc = 0;
    int   start_cyc = 0;
    int   dbl_cnt = 0;
    logic prev_valid = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every rx_valid pulse and flag any pulse wider than one cycle.
    always @(negedge clk) begin
        if (rx_valid) begin
            rec_t r;
            r.d   = data_out;
            r.pe  = parity_err;
            r.fe  = frame_err;
            r.lat = cyc - start_cyc;
            q.push_back(r);
        end
        if (rx_valid && prev_valid) dbl_cnt <= dbl_cnt + 1;
        prev_valid <= rx_valid;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] d, input logic p, input logic s);
        rx = 1'b0;
        start_cyc = cyc;
        clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            clks(CPB);
        end
        rx = p;
        clks(CPB);
        rx = s;
        clks(CPB);
    endtask

    task automatic expect_rec(input string nm, input logic [7:0] d, input logic pe, input logic fe);
        check({nm, "_present"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            rec_t r;
            r = q.pop_front();
            check({nm, "_data"}, 32'(r.d), 32'(d));
            check({nm, "_perr"}, 32'(r.pe), 32'(pe));
            check({nm, "_ferr"}, 32'(r.fe), 32'(fe));
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};

        rx    = 1'b1;
        rst_n = 1'b0;
        clks(5);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_busy", 32'(rx_busy), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        rst_n = 1'b1;
        clks(10);

        // Table-driven frames, each followed by an idle gap long enough for the LED to expire.
        for (int i = 0; i < 7; i++) begin
            send_bits(vecs[i].din, vecs[i].par, vecs[i].stop);
            rx = 1'b1;
            if (i == 0 && q.size() != 0) begin
                check("latency_in_range", 32'(q[0].lat >= 170 && q[0].lat <= 172), 32'd1);
            end
            expect_rec($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe);
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
            check($sformatf("vec%0d_busy", i), 32'(rx_busy), 32'h0);
            clks(150);
            check($sformatf("vec%0d_led_off", i), 32'(led), 32'h0);
            check($sformatf("vec%0d_no_extra", i), 32'(q.size()), 32'd0);
        end

        // Stop bit 0 with the line held low afterwards: one frame_err frame, no retrigger.
        send_bits(8'h3C, 1'b0, 1'b0);
        clks(40);
        expect_rec("break", 8'h3C, 1'b0, 1'b1);
        check("break_led", 32'(led), 32'h0);
        rx = 1'b1;
        clks(30);
        check("break_no_retrigger", 32'(q.size()), 32'd0);
        check("break_busy", 32'(rx_busy), 32'h0);

        // Short low glitch: START rejects it and the flags stay as they were.
        rx = 1'b0;
        clks(4);
        check("glitch_busy_high", 32'(rx_busy), 32'h1);
        rx = 1'b1;
        clks(30);
        check("glitch_busy_low", 32'(rx_busy), 32'h0);
        check("glitch_no_valid", 32'(q.size()), 32'd0);
        check("glitch_data_kept", 32'(data_out), 32'h3C);
        check("glitch_ferr_kept", 32'(frame_err), 32'h1);
        check("glitch_perr_kept", 32'(parity_err), 32'h0);

        // Back-to-back frames with no idle gap between stop and next start.
        send_bits(8'h55, 1'b0, 1'b1);
        send_bits(8'hAA, 1'b0, 1'b1);
        check("b2b_count", 32'(q.size()), 32'd2);
        expect_rec("b2b_first", 8'h55, 1'b0, 1'b0);
        expect_rec("b2b_second", 8'hAA, 1'b0, 1'b0);

        // Reset in the middle of the data bits of 0x77.
        rx = 1'b0;
        clks(CPB);
        rx = 1'b1;
        clks(CPB);
        clks(CPB);
        clks(CPB / 2);
        check("pre_rst_busy", 32'(rx_busy), 32'h1);
        check("pre_rst_led", 32'(led), 32'h1);
        check("pre_rst_data", 32'(data_out), 32'hAA);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_busy", 32'(rx_busy), 32'h0);
        check("mid_rst_led", 32'(led), 32'h0);
        check("mid_rst_valid", 32'(rx_valid), 32'h0);
        clks(5);
        rx = 1'b1;
        rst_n = 1'b1;
        clks(10);
        check("post_rst_no_valid", 32'(q.size()), 32'd0);
        send_bits(8'h12, 1'b0, 1'b1);
        rx = 1'b1;
        clks(5);
        expect_rec("post_rst", 8'h12, 1'b0, 1'b0);
        check("post_rst_led", 32'(led), 32'h1);
        check("post_rst_no_extra", 32'(q.size()), 32'd0);

        check("valid_single_cycle", 32'(dbl_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage; the downstream consumer of the team's 11-bit UART transmit frame.
- Frame format: start(0), 8 data bits LSB first, even parity, stop(1), at BAUD_RATE from a 100 MHz clock.
- Synchronises the asynchronous rx line, samples each bit at mid-bit, checks parity and stop bit.
- Presents the byte with a one-cycle valid strobe plus error flags; drives a status LED.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (10416), clocks per bit period; overridable for simulation; clk_count is 14 bits wide.
- LED_HOLD, 5_000_000, LED on-time in clocks after a good frame (50 ms).

Ports:
- clk  input  1  system clock, 100 MHz, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rx  input  1  UART serial input, asynchronous to clk, idle high.
- data_out  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse: data_out, parity_err and frame_err updated.
- rx_busy  output  1  frame reception in progress.
- parity_err  output  1  last frame failed even-parity check; held until the next rx_valid.
- frame_err  output  1  last frame had stop bit = 0; held until the next rx_valid.
- led  output  1  high for LED_HOLD clocks after an error-free frame.

Behaviour:
- Reset (rst_n low, asynchronous): data_out=0, rx_valid=0, rx_busy=0, parity_err=0, frame_err=0, led=0, state=IDLE, counters=0, both synchroniser flops=1. Reset mid-frame aborts the frame with no rx_valid.
- Synchroniser: two flops produce rx_s; rx_prev holds rx_s delayed one cycle. All decisions use rx_s.
- IDLE: on a falling edge (rx_prev=1, rx_s=0), set clk_count=0, rx_busy=1, go to START. A line that is held low, with no falling edge, never starts a frame.
- START: at clk_count == CLKS_PER_BIT/2-1, sample.
  - Sample 0: clk_count=0, bit_index=0, go to DATA.
  - Sample 1: glitch; go to IDLE, rx_busy=0, no flags change.
- DATA: each time clk_count == CLKS_PER_BIT-1, sample into shift_reg[bit_index] and increment bit_index. After bit 7, go to PARITY. Otherwise clk_count increments.
- PARITY: at CLKS_PER_BIT-1, latch par_bad = sample XOR (^shift_reg). Go to STOP.
- STOP: at CLKS_PER_BIT-1, sample, then in the same edge:
  - data_out <= shift_reg, parity_err <= par_bad, frame_err <= ~sample;
  - rx_valid <= 1 for exactly one cycle; rx_busy <= 0; go to IDLE.
  - If there is no error, led_counter <= LED_HOLD.
- Data and errors: data_out is updated even when an error flag is set.
- Sample timing: all samples fall at mid-bit. The frame ends mid-stop-bit, so a back-to-back next start edge is caught.
- Stop bit = 0 (break): after frame_err the line is low, and the receiver waits in IDLE for high then a falling edge.
- LED: while led_counter > 0, led=1 and led_counter decrements; otherwise led=0. A new good frame reloads led_counter.
- Latency: rx_valid rises CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 3 clocks (±1) after the rx falling edge.

Optional Feature:
- RX_MAJORITY_EN defined: each sample (START/DATA/PARITY/STOP) is the 2-of-3 majority of rx_s taken at sample point −2, −1 and 0 clocks. One isolated glitch clock at the sample point is rejected.
- RX_MAJORITY_EN undefined: single rx_s sample at the sample point; no extra registers.

Test Plan:
- CLKS_PER_BIT=16. Send 0xA5 with parity=0, stop=1 -> one rx_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, led=1 the next cycle.
- Send 0x01 with parity=0 (wrong) -> rx_valid, data_out=0x01, parity_err=1, frame_err=0, led stays 0.
- Send 0x3C with stop=0 -> rx_valid, data_out=0x3C, frame_err=1. With rx held low 40 clocks then high, no further rx_valid.
- Drive rx low for 4 clocks then high -> START rejects, rx_busy returns 0, no rx_valid, flags unchanged.
- Two frames back-to-back (0x55 then 0xAA, no idle gap) -> two rx_valid pulses with data_out 0x55 then 0xAA, no errors.
- Deassert rst_n during DATA of frame 0x77 -> all outputs 0 immediately. After release, send 0x12 -> data_out=0x12 received cleanly.
